bp_me_dma_wormhole_arbiter: RTL
===============================

// Module: bp_me_dma_wormhole_arbiter
// PURPOSE
//  Wormhole-aware round-robin arbiter sharing one outgoing DMA NoC ready-and link among
//  num_req_p memory-complex L2E nodes. It locks the grant from header to last flit so packets never
//  interleave. Sits between per-column L2E dma_link_o and the N or S edge DMA link.
// PARAMETERS
//  num_req_p    2   requesters (one per mc column, = mc_x_dim_p)
//  flit_width_p 64  DMA NoC flit width (= dma_noc_flit_width_p)
//  cord_width_p 7   header cord field, flit[cord_width_p-1:0]
//  len_width_p  4   header len field, flit[cord_width_p+:len_width_p] = body flits after header
// PORTS
//  clk_i        in   1                          clock
//  reset_i      in   1                          async, active-high
//  data_i       in   num_req_p*flit_width_p     per-requester flit
//  v_i          in   num_req_p                  per-requester valid
//  ready_and_o  out  num_req_p                  per-requester ready
//  data_o       out  flit_width_p               muxed flit to link
//  v_o          out  1                          link valid
//  ready_and_i  in   1                          link ready
//  grant_o      out  num_req_p                  one-hot current owner, 0 when none
//  busy_o       out  1                          1 in HDR or BODY
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=IDLE, rr_ptr=0, count=0, gnt_r=0.
//    v_o=0, ready_and_o=0, grant_o=0, busy_o=0 while reset_i=1.
//  Handshake = v_o & ready_and_i. Zero-latency combinational pass-through; no flit storage.
//  v_o and grant selection never depend on ready_and_i. ready_and_o[k]=ready_and_i & grant_o[k].
//  IDLE: if |v_i, sel = first requester with v_i=1 at or after rr_ptr (cyclic);
//    grant_o=onehot(sel), v_o=1, data_o=data_i[sel].
//    handshake & len==0 -> stay IDLE, rr_ptr=sel+1 mod num_req_p.
//    handshake & len>0  -> BODY, count=len, gnt_r=sel.
//    no handshake       -> HDR, gnt_r=sel (grant frozen; later-arriving higher-priority v_i ignored).
//  HDR: grant_o=onehot(gnt_r), v_o=v_i[gnt_r]; on handshake same len decode as IDLE.
//    rr_ptr advances only on packet completion.
//  BODY: grant_o=onehot(gnt_r), v_o=v_i[gnt_r]. Each handshake count-=1.
//    Handshake with count==1 -> IDLE, rr_ptr=gnt_r+1. A v_i[gnt_r] bubble holds state.
//  count is len_width_p bits. len=2^len_width_p-1 is legal, no wrap. count never decrements past 1.
//  Non-granted requesters see ready_and_o=0 in every state. Their v_i is observed only in IDLE.
//  Reset mid-packet: immediate return to IDLE, partial packet dropped; upstream also resets.
//  num_req_p==1: degenerate, ptr constant 0, still tracks packets (busy_o valid).
// STRUCTURE
//  bp_me_pkg: header field offsets/widths for the DMA wormhole header (cord, len), shared with
//    the L2E DMA encoder.
//  Sub-module bp_me_dma_rr_pick: combinational cyclic priority pick (v_i, rr_ptr -> one-hot sel).
//    Pointer register stays in this module for async reset.
//  Top: 3-state FSM {IDLE,HDR,BODY}, count, gnt_r, rr_ptr, output mux.
// TESTING
//  1 v_i=2'b11 both len=0, ready=1 -> req0 then req1 then req0 on consecutive cycles; grant_o 01,10,01.
//  2 req1 len=3, ready=1, req0 raises v mid-packet -> 4 flits of req1 contiguous, then req0 granted.
//  3 req0 header valid, ready=0 for 5 cycles, v_i[1] raised at cycle 2 -> grant stays 01, state HDR,
//    ready_and_o=00.
//  4 len=15 packet with ready toggling 1/0 and v_i bubbles -> exactly 16 handshakes, then IDLE, rr_ptr=1.
//  5 reset_i pulsed during BODY after 2 of 5 flits -> v_o/grant_o/busy_o 0 immediately;
//    next packet arbitrated from rr_ptr=0.
//  6 Random: 2-4 requesters, random len/stall; scoreboard checks no interleave and no starvation
//    (wait <= num_req_p packets).

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared definitions for the DMA wormhole network path.
//
// Contents:
//   DMA_CORD_WIDTH / DMA_LEN_WIDTH - default widths of the two header fields.
//       Header layout is flit[cord-1:0] = destination cord and
//       flit[cord +: len] = number of body flits that follow the header.
//       The L2E DMA encoder builds headers with the same layout.
//   arb_state_e - states of the wormhole arbiter.
//   ptr_width() - bits needed to index N requesters; never less than 1.
package bp_me_pkg;

    localparam int unsigned DMA_CORD_WIDTH = 7;
    localparam int unsigned DMA_LEN_WIDTH  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HDR  = 2'd1,
        ARB_BODY = 2'd2
    } arb_state_e;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_me_dma_rr_pick.sv
// Combinational cyclic-priority picker.
//
// Returns the first requester with a valid request at or after ptr_i,
// wrapping around past the last requester.  It holds no state; the
// round-robin pointer is registered in the arbiter that uses it.
//
// Ports:
//   v_i       in  num_req_p  per-requester request
//   ptr_i     in  ptr width  requester with highest priority
//   sel_oh_o  out num_req_p  one-hot winner, 0 when nobody requests
//   sel_idx_o out ptr width  winner index, 0 when nobody requests
//   sel_v_o   out 1          some requester is asking
module bp_me_dma_rr_pick
    import bp_me_pkg::*;
#(
    parameter  int unsigned num_req_p = 2,
    localparam int unsigned ptr_w_lp  = ptr_width(num_req_p)
) (
    input  logic [num_req_p-1:0] v_i,
    input  logic [ptr_w_lp-1:0]  ptr_i,
    output logic [num_req_p-1:0] sel_oh_o,
    output logic [ptr_w_lp-1:0]  sel_idx_o,
    output logic                 sel_v_o
);

    logic [ptr_w_lp-1:0] cand;

    // Walk the requesters in priority order starting at the pointer.
    // The first requester found wins.
    always_comb begin
        sel_oh_o  = '0;
        sel_idx_o = '0;
        sel_v_o   = 1'b0;
        cand      = '0;
        for (int i = 0; i < int'(num_req_p); i++) begin
            cand = ptr_w_lp'((int'(ptr_i) + i) % int'(num_req_p));
            if (!sel_v_o && v_i[cand]) begin
                sel_v_o        = 1'b1;
                sel_idx_o      = cand;
                sel_oh_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_me_dma_wormhole_arbiter.sv
// Round-robin arbiter for wormhole packets.
//
// Several L2E DMA links share one outgoing DMA NoC ready/valid link.
// A requester keeps the grant from the cycle its header is first selected
// until its last body flit is accepted, so packets never interleave.
// Flits pass straight through without storage.
//
// Ports:
//   clk_i        in  1                       clock
//   reset_i      in  1                       asynchronous reset, active high
//   data_i       in  num_req_p*flit_width_p  one flit per requester
//   v_i          in  num_req_p               valid per requester
//   ready_and_o  out num_req_p               ready per requester; only the owner sees ready
//   data_o       out flit_width_p            flit from the selected requester
//   v_o          out 1                       valid on the shared link
//   ready_and_i  in  1                       ready from the shared link
//   grant_o      out num_req_p               one-hot owner, 0 when nobody is selected
//   busy_o       out 1                       a packet is locked (header waiting or body)
module bp_me_dma_wormhole_arbiter
    import bp_me_pkg::*;
#(
    parameter  int unsigned num_req_p    = 2,
    parameter  int unsigned flit_width_p = 64,
    parameter  int unsigned cord_width_p = DMA_CORD_WIDTH,
    parameter  int unsigned len_width_p  = DMA_LEN_WIDTH,
    localparam int unsigned ptr_w_lp     = ptr_width(num_req_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p*flit_width_p-1:0] data_i,
    input  logic [num_req_p-1:0]              v_i,
    output logic [num_req_p-1:0]              ready_and_o,
    output logic [flit_width_p-1:0]           data_o,
    output logic                              v_o,
    input  logic                              ready_and_i,
    output logic [num_req_p-1:0]              grant_o,
    output logic                              busy_o
);

    arb_state_e             state_q, state_d;
    logic [ptr_w_lp-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ptr_w_lp-1:0]    gnt_q, gnt_d;
    logic [len_width_p-1:0] count_q, count_d;

    logic [num_req_p-1:0]   pick_oh;
    logic [ptr_w_lp-1:0]    pick_idx;
    logic                   pick_v;
    logic [ptr_w_lp-1:0]    cur_idx;
    logic [len_width_p-1:0] hdr_len;
    logic                   handshake;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(num_req_p - 1)) ? '0 : p + 1'b1;
    endfunction

    bp_me_dma_rr_pick #(
        .num_req_p (num_req_p)
    ) u_pick (
        .v_i       (v_i),
        .ptr_i     (rr_ptr_q),
        .sel_oh_o  (pick_oh),
        .sel_idx_o (pick_idx),
        .sel_v_o   (pick_v)
    );

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            count_q  <= count_d;
        end
    end

    // Output mux.  While idle, the picker chooses the owner on the fly.
    // Once locked, only the registered owner is visible.  The outputs are
    // gated with reset_i because in IDLE, v_o would otherwise follow v_i.
    always_comb begin
        cur_idx = gnt_q;
        grant_o = '0;
        v_o     = 1'b0;
        if (state_q == ARB_IDLE) begin
            cur_idx = pick_idx;
            grant_o = pick_oh;
            v_o     = pick_v;
        end else begin
            grant_o[gnt_q] = 1'b1;
            v_o            = v_i[gnt_q];
        end
        busy_o = (state_q != ARB_IDLE);
        if (reset_i) begin
            grant_o = '0;
            v_o     = 1'b0;
            busy_o  = 1'b0;
        end
        data_o      = data_i[cur_idx*flit_width_p +: flit_width_p];
        ready_and_o = grant_o & {num_req_p{ready_and_i}};
    end

    assign handshake = v_o & ready_and_i;
    assign hdr_len   = data_o[cord_width_p +: len_width_p];

    // Next-state logic.  The pointer moves only when a packet completes.
    // A header that is not accepted freezes the grant in HDR, so a later
    // request from a higher-priority requester cannot take the link.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        count_d  = count_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_v) begin
                    if (!handshake) begin
                        state_d = ARB_HDR;
                        gnt_d   = pick_idx;
                    end else if (hdr_len == '0) begin
                        rr_ptr_d = next_ptr(pick_idx);
                    end else begin
                        state_d = ARB_BODY;
                        gnt_d   = pick_idx;
                        count_d = hdr_len;
                    end
                end
            end
            ARB_HDR: begin
                if (handshake) begin
                    if (hdr_len == '0) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = next_ptr(gnt_q);
                    end else begin
                        state_d = ARB_BODY;
                        count_d = hdr_len;
                    end
                end
            end
            ARB_BODY: begin
                if (handshake) begin
                    if (count_q == len_width_p'(1)) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = next_ptr(gnt_q);
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule
